serial_alu_sequencer: RTL and testbench
=======================================

Name: serial_alu_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit ALU operation by driving one 1-bit ALU slice, one bit per clock, LSB first.
- Decodes the 6-bit funct code, sets the slice's invert-b and carry-in, holds the running carry, and shifts result bits into a register.
- Sits between instruction decode and register writeback, using a start/done handshake.
- Trades latency (WIDTH cycles) for area: one slice instead of WIDTH slices.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CW, 6, control (funct) code width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- ctl  input  CW  funct code: 32 add, 34 sub, 36 and, 37 or.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  operation result; held until the next accepted start.
- cout  output  1  carry out of MSB (add/sub); 0 for logic ops.
- overflow  output  1  signed overflow (add/sub); 0 for logic ops.
- zero  output  1  result == 0.
- illegal  output  1  one-cycle pulse when start carries an unsupported ctl.

Behaviour:
- Reset values (asynchronous): state=IDLE; busy=0, done=0, illegal=0, result=0, cout=0, overflow=0, zero=1; carry, bit counter and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: start=1 with legal ctl.
  - Latch a, b and ctl.
  - Bit counter = 0.
  - carry = 1 for sub, else 0.
  - invb = 1 for sub, else 0.
- IDLE, illegal ctl with start=1: stay in IDLE, illegal=1 for one cycle, result and flags unchanged.
- RUN, each edge:
  - Slice gets a_q[cnt], b_q[cnt], invb, carry.
  - Slice sum is shifted into result from the MSB (right shift), so bit 0 ends at result[0].
  - carry <= slice cout.
  - cnt increments.
- RUN -> DONE: on the edge that processes bit WIDTH-1. At that edge:
  - cout <= final carry (add/sub).
  - overflow <= carry into MSB XOR carry out of MSB (add/sub).
  - zero <= (final result == 0).
- Latency: start sampled at edge E0; bits processed at edges E1..E_WIDTH; done high in the cycle after E_WIDTH (exactly WIDTH cycles after the start-sampling edge).
- busy is high exactly WIDTH cycles (the cycles after E0 through E_WIDTH).
- DONE: done=1 for one cycle, then IDLE.
  - start with legal ctl in DONE is accepted and goes directly to RUN (back-to-back, no idle bubble).
  - Illegal start in DONE pulses illegal and goes to IDLE.
- start during RUN is ignored: no queueing, no illegal pulse, operands not re-latched.
- Input changes to a, b or ctl during RUN have no effect.
- Sub semantics: a + ~b + 1. cout=1 means no borrow.
- Logic ops:
  - Carry chain is ignored; cout=0, overflow=0.
  - The slice still runs WIDTH cycles, so latency is identical for all ops.
- Reset asserted mid-RUN: immediately returns to the reset values above. The partial result is discarded and done is not pulsed.
- result, cout, overflow and zero change only at the RUN->DONE edge and at reset.

Decomposition:
- Shared package alu_pkg:
  - funct constants FN_ADD=6'd32, FN_SUB=6'd34, FN_AND=6'd36, FN_OR=6'd37.
  - State enum {IDLE, RUN, DONE}.
  - Helper function is_legal_fn.
  - The 1-bit slice and any future ALU control unit import the same constants.
- Sub-module alu_bit_slice:
  - Purely combinational 1-bit slice.
  - Ports ctl, ai, bi, invb, cin, sum, cout.
  - Internal mux selects and/or/adder output by ctl.
  - Instantiated exactly once.
- Counter width: clog2(WIDTH).

Test Plan (WIDTH=8):
- add a=0x7F, b=0x01 -> done exactly 8 cycles after the start edge; result=0x80, cout=0, overflow=1, zero=0.
- sub a=0x05, b=0x07 -> result=0xFE, cout=0, overflow=0. Then sub a=0x07, b=0x07 -> result=0x00, cout=1, zero=1.
- and a=0xF0, b=0x3C -> 0x30. Then or issued on the done cycle (back-to-back) -> or 0xF0|0x0F=0xFF. Check busy has no gap and cout=overflow=0.
- start with ctl=6'd42 in IDLE -> illegal pulse one cycle, busy stays 0, result unchanged. Then start with ctl=add in RUN plus a changing `a` input -> ignored, result unaffected.
- Reset asserted at bit 4 of an add 0xFF+0x01 -> all outputs at reset values immediately, no done pulse. New add 0x01+0x01 after reset -> 0x02.
- Randomized 200 ops across all four funct codes, compared against a reference model on result, cout, overflow and zero. Assert done never coincides with busy.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes, sequencer states and decode helpers.
package alu_pkg;

  localparam int unsigned FN_W = 6;

  localparam logic [FN_W-1:0] FN_ADD = 6'd32;
  localparam logic [FN_W-1:0] FN_SUB = 6'd34;
  localparam logic [FN_W-1:0] FN_AND = 6'd36;
  localparam logic [FN_W-1:0] FN_OR  = 6'd37;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the funct codes this ALU implements.
  function automatic logic is_legal_fn(input logic [FN_W-1:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR};
  endfunction

  // True for codes that use the carry chain.
  function automatic logic is_arith_fn(input logic [FN_W-1:0] fn);
    return fn inside {FN_ADD, FN_SUB};
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_if.sv
// Start/done request bus between decode and the serial ALU.
interface serial_alu_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
);
  logic             start;
  logic [CW-1:0]    ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             illegal;

  modport master (
    output start, ctl, a, b,
    input  busy, done, result, cout, overflow, zero, illegal
  );

  modport slave (
    input  start, ctl, a, b,
    output busy, done, result, cout, overflow, zero, illegal
  );
endinterface

// File: rtl/serial_alu_sequencer_bit_slice.sv
// One-bit ALU slice: full adder with optional b inversion, plus and/or.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic [FN_W-1:0] ctl,
  input  logic            ai,
  input  logic            bi,
  input  logic            invb,
  input  logic            cin,
  output logic            sum,
  output logic            cout
);

  logic bx;
  logic add_sum;

  // Adder path always computed; ctl selects which result leaves the slice.
  always_comb begin
    bx      = bi ^ invb;
    add_sum = ai ^ bx ^ cin;
    cout    = (ai & bx) | (cin & (ai ^ bx));
    case (ctl)
      FN_AND:  sum = ai & bi;
      FN_OR:   sum = ai | bi;
      default: sum = add_sum;
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: one slice, one bit per clock, LSB first.
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_alu_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [FN_W-1:0]   ctl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q;
  logic              invb_q;
  logic [WIDTH-2:0]  sh_q;
  logic [WIDTH-1:0]  result_q;
  logic              cout_q;
  logic              overflow_q;
  logic              zero_q;
  logic              busy_q;
  logic              done_q;
  logic              illegal_q;
  logic              busy_d;
  logic              done_d;
  logic              illegal_d;

  logic [FN_W-1:0]   fn_c;
  logic              legal_c;
  logic              open_c;
  logic              accept_c;
  logic              last_c;
  logic              arith_c;
  logic [WIDTH-1:0]  res_c;
  logic              slice_sum;
  logic              slice_cout;

  alu_bit_slice u_slice (
    .ctl  (ctl_q),
    .ai   (a_q[cnt_q]),
    .bi   (b_q[cnt_q]),
    .invb (invb_q),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Request decode and datapath helpers.
  always_comb begin
    fn_c     = FN_W'(bus.ctl);
    legal_c  = is_legal_fn(fn_c) && (CW'(fn_c) == bus.ctl);
    open_c   = (state_q == IDLE) || (state_q == DONE);
    accept_c = open_c && bus.start && legal_c;
    last_c   = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
    arith_c  = is_arith_fn(ctl_q);
    res_c    = {slice_sum, sh_q};
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; DONE may chain straight into another RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = accept_c ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the handshake outputs.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    busy_d    = (state_d == RUN);
    done_d    = (state_d == DONE);
    illegal_d = open_c && bus.start && !legal_c;
  end

  // Operand latch, bit-serial shift and final result/flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      invb_q     <= 1'b0;
      sh_q       <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
    end else if (accept_c) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      ctl_q   <= fn_c;
      cnt_q   <= '0;
      carry_q <= (fn_c == FN_SUB);
      invb_q  <= (fn_c == FN_SUB);
    end else if (state_q == RUN) begin
      sh_q    <= res_c[WIDTH-1:1];
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        result_q   <= res_c;
        cout_q     <= arith_c & slice_cout;
        overflow_q <= arith_c & (carry_q ^ slice_cout);
        zero_q     <= (res_c == '0);
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench for the bit-serial ALU sequencer (WIDTH=8).
module tb_serial_alu_sequencer;

  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 40;

  localparam logic [5:0] C_ADD = 6'd32;
  localparam logic [5:0] C_SUB = 6'd34;
  localparam logic [5:0] C_AND = 6'd36;
  localparam logic [5:0] C_OR  = 6'd37;

  typedef struct {
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   ill_q[$];
  exp_t mon_e;
  int   mon_c;
  logic [5:0] codes [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_alu_sequencer_if #(.WIDTH(W), .CW(6)) bus ();

  serial_alu_sequencer #(.WIDTH(W), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic legal(input logic [5:0] fn);
    return (fn == C_ADD) || (fn == C_SUB) || (fn == C_AND) || (fn == C_OR);
  endfunction

  // Reference: whole-word arithmetic, flags from sign rules.
  function automatic exp_t model(input logic [5:0] fn, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int due);
    exp_t e;
    logic [W:0] s;
    e.result = '0; e.cout = 1'b0; e.overflow = 1'b0; e.due = due;
    case (fn)
      C_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.result = s[W-1:0]; e.cout = s[W];
        e.overflow = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      C_SUB: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.result = s[W-1:0]; e.cout = s[W];
        e.overflow = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
      end
      C_AND: e.result = x & y;
      C_OR:  e.result = x | y;
      default: e.result = '0;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports completion.
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_busy_overlap", 32'(bus.done & bus.busy), 32'd0);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result",   32'(bus.result),   32'(mon_e.result));
          chk("cout",     32'(bus.cout),     32'(mon_e.cout));
          chk("overflow", 32'(bus.overflow), 32'(mon_e.overflow));
          chk("zero",     32'(bus.zero),     32'(mon_e.zero));
          chk("latency",  32'(cyc),          32'(mon_e.due));
        end
      end
      if (bus.illegal) begin
        if (ill_q.size() == 0) begin
          chk("unexpected_illegal", 32'(bus.illegal), 32'd0);
        end else begin
          mon_c = ill_q.pop_front();
          chk("illegal_cycle", 32'(cyc), 32'(mon_c));
        end
      end
    end
  end

  // Drive one start cycle and record what the DUT must report for it.
  task automatic issue(input logic [5:0] fn, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.start = 1'b1; bus.ctl = fn; bus.a = x; bus.b = y;
    if (legal(fn)) exp_q.push_back(model(fn, x, y, cyc + 1 + int'(W)));
    else           ill_q.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.ctl = 6'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < int'(TIMEOUT)) begin
      @(negedge clk);
      if (bus.done) break;
      n++;
    end
    chk(name, 32'(bus.done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_illegal"},  32'(bus.illegal),  32'd0);
    chk({tag, "_result"},   32'(bus.result),   32'd0);
    chk({tag, "_cout"},     32'(bus.cout),     32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_zero"},     32'(bus.zero),     32'd1);
  endtask

  initial begin
    logic [W-1:0] held;
    logic [5:0]   fn;
    codes = '{C_ADD, C_SUB, C_AND, C_OR};
    bus.start = 1'b0; bus.ctl = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    idle(2);
    chk_reset_values("reset");
    rst = 1'b0;
    idle(1);

    // Add with signed overflow.
    issue(C_ADD, 8'h7F, 8'h01);
    wait_done("add_done_seen");
    chk("add_result_const", 32'(bus.result), 32'h80);
    chk("add_ovf_const", 32'(bus.overflow), 32'd1);

    // Subtract with borrow, then equal operands.
    idle(1);
    issue(C_SUB, 8'h05, 8'h07);
    wait_done("sub1_done_seen");
    chk("sub1_result_const", 32'(bus.result), 32'hFE);
    chk("sub1_cout_const", 32'(bus.cout), 32'd0);
    issue(C_SUB, 8'h07, 8'h07);
    wait_done("sub2_done_seen");
    chk("sub2_cout_const", 32'(bus.cout), 32'd1);
    chk("sub2_zero_const", 32'(bus.zero), 32'd1);

    // AND, then OR issued on the done cycle with no busy bubble.
    idle(2);
    issue(C_AND, 8'hF0, 8'h3C);
    wait_done("and_done_seen");
    chk("and_result_const", 32'(bus.result), 32'h30);
    issue(C_OR, 8'hF0, 8'h0F);
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
    end
    wait_done("or_done_seen");
    chk("or_result_const", 32'(bus.result), 32'hFF);
    chk("or_cout_const", 32'(bus.cout), 32'd0);
    chk("or_ovf_const", 32'(bus.overflow), 32'd0);

    // Illegal code in IDLE: one-cycle pulse, nothing else moves.
    idle(2);
    held = bus.result;
    issue(6'd42, 8'h11, 8'h22);
    @(negedge clk);
    chk("illegal_busy", 32'(bus.busy), 32'd0);
    chk("illegal_pulse", 32'(bus.illegal), 32'd1);
    @(negedge clk);
    chk("illegal_one_cycle", 32'(bus.illegal), 32'd0);
    chk("illegal_result_held", 32'(bus.result), 32'(held));

    // Starts and operand changes during RUN are ignored.
    idle(1);
    issue(C_ADD, 8'h03, 8'h04);
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b1; bus.ctl = C_ADD; bus.a = W'($urandom);
      idle(1);
    end
    bus.start = 1'b0;
    wait_done("run_ignore_done_seen");
    chk("run_ignore_result", 32'(bus.result), 32'h07);

    // Reset in the middle of an add: immediate reset values, no done.
    idle(2);
    bus.start = 1'b1; bus.ctl = C_ADD; bus.a = 8'hFF; bus.b = 8'h01;
    idle(1);
    bus.start = 1'b0;
    idle(4);
    rst = 1'b1;
    #1;
    chk_reset_values("midrun_reset");
    idle(1);
    rst = 1'b0;
    idle(12);
    chk("post_reset_idle", 32'(bus.busy), 32'd0);
    issue(C_ADD, 8'h01, 8'h01);
    wait_done("post_reset_done_seen");
    chk("post_reset_result", 32'(bus.result), 32'h02);

    // Randomized traffic: mixed codes, gaps, back-to-back and illegal starts.
    idle(1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        fn = 6'($urandom_range(0, 63));
        if (!legal(fn)) begin
          issue(fn, W'($urandom), W'($urandom));
          idle(1);
        end
      end
      fn = codes[$urandom_range(0, 3)];
      issue(fn, W'($urandom), W'($urandom));
      wait_done("rand_done_seen");
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("illegal_drained", 32'(ill_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
